// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - multi-word instruction fetch with queue, branch redirect and discard
//
// Fetches INSTR_BYTES memory words per instruction (first word lands in the MSBs),
// buffers complete instructions in a QUEUE_DEPTH-entry shift queue and hands them
// to decode over a valid/ready handshake. Branches flush the queue and the partial
// assembly; a read still in flight at the branch is waited out and its data dropped.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              permits new memory requests
//   mem_req/mem_addr    read request and address, held until mem_ack
//   mem_ack/mem_rdata   read completion and data (same cycle)
//   instr_valid/ready   decode handshake for the queue head
//   instr/instr_addr    head instruction and address of its first word
//   branch_*            single-cycle redirect (absolute target or signed offset)
//   ip                  address of the next word to request
//   busy                request outstanding or discard pending
module instruction_fetch_unit #(
    parameter int MEMORY_ADDRESS_BITS = 8,
    parameter int MEMORY_DATA_BITS    = 8,
    parameter int INSTR_BYTES         = 2,
    parameter int JUMP_OFFSET_BITS    = 8,
    parameter int QUEUE_DEPTH         = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enable,
    output logic                                    mem_req,
    output logic [MEMORY_ADDRESS_BITS-1:0]          mem_addr,
    input  logic                                    mem_ack,
    input  logic [MEMORY_DATA_BITS-1:0]             mem_rdata,
    output logic                                    instr_valid,
    input  logic                                    instr_ready,
    output logic [INSTR_BYTES*MEMORY_DATA_BITS-1:0] instr,
    output logic [MEMORY_ADDRESS_BITS-1:0]          instr_addr,
    input  logic                                    branch_valid,
    input  logic                                    branch_relative,
    input  logic [MEMORY_ADDRESS_BITS-1:0]          branch_target,
    input  logic [JUMP_OFFSET_BITS-1:0]             branch_offset,
    output logic [MEMORY_ADDRESS_BITS-1:0]          ip,
    output logic                                    busy
);
    localparam int AW  = MEMORY_ADDRESS_BITS;
    localparam int DW  = MEMORY_DATA_BITS;
    localparam int IW  = INSTR_BYTES * MEMORY_DATA_BITS;
    localparam int WCW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(INSTR_BYTES - 1);
    localparam logic [AW-1:0]  ONE_ADDR  = AW'(1);
    localparam logic [AW-1:0]  IB_ADDR   = AW'(INSTR_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t                 state, state_n;
    logic                   mem_req_n, busy_n;
    logic [AW-1:0]          mem_addr_n, ip_n;
    logic [AW-1:0]          start_addr, start_addr_n;
    logic [AW-1:0]          last_next, last_next_n, last_next_eff;
    logic [AW-1:0]          target;
    logic [WCW-1:0]         word_cnt, word_cnt_n;
    logic [DW-1:0]          asm_q [INSTR_BYTES];
    logic [DW-1:0]          asm_n [INSTR_BYTES];
    logic [IW-1:0]          q_data   [QUEUE_DEPTH];
    logic [IW-1:0]          q_data_n [QUEUE_DEPTH];
    logic [AW-1:0]          q_addr   [QUEUE_DEPTH];
    logic [AW-1:0]          q_addr_n [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_vld, q_vld_n;
    logic                   pop, ack, push, found;
    logic [IW-1:0]          push_data;
    logic [AW-1:0]          push_addr;
    int                     count_s;

    // Entry 0 of the shift queue is the head, so the decode outputs come straight from flops.
    assign instr_valid = q_vld[0];
    assign instr       = q_data[0];
    assign instr_addr  = q_addr[0];

    always_comb begin
        pop  = q_vld[0] && instr_ready;
        // An ack with no request pending (e.g. a late ack after reset) is ignored.
        ack  = mem_req && mem_ack;

        last_next_eff = pop ? (q_addr[0] + IB_ADDR) : last_next;
        target        = branch_relative ? (last_next_eff + AW'(signed'(branch_offset)))
                                        : branch_target;
        last_next_n   = last_next_eff;

        // Queue after this cycle's pop, before any push or flush.
        q_data_n = q_data;
        q_addr_n = q_addr;
        if (pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                q_data_n[i] = q_data[i+1];
                q_addr_n[i] = q_addr[i+1];
            end
        end
        q_vld_n = pop ? (q_vld >> 1) : q_vld;
        count_s = 0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            count_s = count_s + int'(q_vld_n[i]);
        end

        state_n      = state;
        mem_req_n    = mem_req;
        mem_addr_n   = mem_addr;
        ip_n         = ip;
        word_cnt_n   = word_cnt;
        asm_n        = asm_q;
        start_addr_n = start_addr;
        push         = 1'b0;

        case (state)
            IDLE: begin
                if (enable && (!q_vld[QUEUE_DEPTH-1] || pop)) begin
                    state_n    = REQ;
                    mem_req_n  = 1'b1;
                    mem_addr_n = ip;
                end
            end
            REQ: begin
                if (ack) begin
                    asm_n[word_cnt] = mem_rdata;
                    ip_n            = ip + ONE_ADDR;
                    if (word_cnt == '0) begin
                        start_addr_n = mem_addr;
                    end
                    if (word_cnt != LAST_WORD) begin
                        word_cnt_n = word_cnt + 1'b1;
                        if (enable) begin
                            mem_addr_n = ip + ONE_ADDR;
                        end else begin
                            state_n   = IDLE;
                            mem_req_n = 1'b0;
                        end
                    end else begin
                        push       = 1'b1;
                        word_cnt_n = '0;
                        // Keep going only if a slot stays free after this push.
                        if (enable && (count_s + 1 < QUEUE_DEPTH)) begin
                            mem_addr_n = ip + ONE_ADDR;
                        end else begin
                            state_n   = IDLE;
                            mem_req_n = 1'b0;
                        end
                    end
                end
            end
            DISCARD: begin
                // The stale read completes here; its data is never captured.
                if (ack) begin
                    state_n    = enable ? REQ : IDLE;
                    mem_req_n  = enable;
                    mem_addr_n = ip;
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase

        if (branch_valid) begin
            push       = 1'b0;
            word_cnt_n = '0;
            ip_n       = target;
            if (mem_req && !mem_ack) begin
                state_n    = DISCARD;
                mem_req_n  = 1'b1;
                mem_addr_n = mem_addr;
            end else begin
                state_n    = enable ? REQ : IDLE;
                mem_req_n  = enable;
                mem_addr_n = target;
            end
        end

        push_data = '0;
        for (int i = 0; i < INSTR_BYTES; i++) begin
            push_data[IW-1-i*DW -: DW] = asm_n[i];
        end
        push_addr = (word_cnt == '0) ? mem_addr : start_addr;

        found = 1'b0;
        if (branch_valid) begin
            q_vld_n = '0;
        end else if (push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (!found && !q_vld_n[i]) begin
                    q_vld_n[i]  = 1'b1;
                    q_data_n[i] = push_data;
                    q_addr_n[i] = push_addr;
                    found       = 1'b1;
                end
            end
        end

        busy_n = mem_req_n || (state_n == DISCARD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ip         <= '0;
            busy       <= 1'b0;
            word_cnt   <= '0;
            start_addr <= '0;
            last_next  <= '0;
            q_vld      <= '0;
            for (int i = 0; i < INSTR_BYTES; i++) begin
                asm_q[i] <= '0;
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
        end else begin
            state      <= state_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            ip         <= ip_n;
            busy       <= busy_n;
            word_cnt   <= word_cnt_n;
            start_addr <= start_addr_n;
            last_next  <= last_next_n;
            q_vld      <= q_vld_n;
            asm_q      <= asm_n;
            q_data     <= q_data_n;
            q_addr     <= q_addr_n;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_addr;
    logic        branch_valid;
    logic        branch_relative;
    logic [7:0]  branch_target;
    logic [7:0]  branch_offset;
    logic [7:0]  ip;
    logic        busy;

    logic [7:0]  mem [256];
    int          lat;
    int          wc;
    int          errors = 0;
    int          checks = 0;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_addr      (instr_addr),
        .branch_valid    (branch_valid),
        .branch_relative (branch_relative),
        .branch_target   (branch_target),
        .branch_offset   (branch_offset),
        .ip              (ip),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Memory responder: acks once the request has waited lat cycles.
    always_comb begin
        mem_rdata = mem[mem_addr];
        mem_ack   = mem_req && (wc >= lat);
    end

    always_ff @(posedge clk) begin
        if (reset) wc <= 0;
        else if (mem_req && mem_ack) wc <= 0;
        else if (mem_req) wc <= wc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        branch_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!instr_valid && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, instr_valid}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[8'hFF] = 8'hAB;
        enable = 1'b1; instr_ready = 1'b1; lat = 0;
        branch_relative = 1'b0; branch_target = 8'h00; branch_offset = 8'h00;

        // Reset values
        reset = 1'b1; branch_valid = 1'b0;
        tick(); tick();
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_mem_addr", {24'b0, mem_addr}, 0);
        chk("rst_ip", {24'b0, ip}, 0);
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_instr", {16'b0, instr}, 0);
        chk("rst_instr_addr", {24'b0, instr_addr}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;

        // 1: basic two-word fetch, zero-wait
        tick();
        chk("t1_req", {31'b0, mem_req}, 1);
        chk("t1_addr0", {24'b0, mem_addr}, 0);
        chk("t1_busy", {31'b0, busy}, 1);
        tick();
        chk("t1_ip1", {24'b0, ip}, 1);
        chk("t1_not_valid", {31'b0, instr_valid}, 0);
        tick();
        chk("t1_valid", {31'b0, instr_valid}, 1);
        chk("t1_instr", {16'b0, instr}, 32'h1234);
        chk("t1_instr_addr", {24'b0, instr_addr}, 0);
        chk("t1_ip2", {24'b0, ip}, 2);

        // 2: queue fills, fetch stalls, one pop restarts it
        instr_ready = 1'b0;
        apply_reset();
        repeat (5) tick();
        chk("t2_stall_req", {31'b0, mem_req}, 0);
        chk("t2_ip4", {24'b0, ip}, 4);
        chk("t2_valid", {31'b0, instr_valid}, 1);
        chk("t2_head", {16'b0, instr}, 32'h1234);
        tick(); tick();
        chk("t2_still_idle", {31'b0, mem_req}, 0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_second", {16'b0, instr}, 32'h5678);
        chk("t2_second_addr", {24'b0, instr_addr}, 2);
        chk("t2_restart_req", {31'b0, mem_req}, 1);
        chk("t2_restart_addr", {24'b0, mem_addr}, 4);

        // 3: absolute branch during a slow read at 0x05
        lat = 2; instr_ready = 1'b1;
        apply_reset();
        begin
            int n = 0;
            while (!(mem_req && mem_addr == 8'h05) && n < 60) begin
                tick();
                n++;
            end
        end
        chk("t3_reach_05", {31'b0, (mem_req && mem_addr == 8'h05)}, 1);
        branch_valid = 1'b1; branch_relative = 1'b0; branch_target = 8'h80;
        tick();
        branch_valid = 1'b0;
        chk("t3_hold_req", {31'b0, mem_req}, 1);
        chk("t3_hold_addr", {24'b0, mem_addr}, 8'h05);
        chk("t3_busy", {31'b0, busy}, 1);
        chk("t3_flushed", {31'b0, instr_valid}, 0);
        chk("t3_ip", {24'b0, ip}, 8'h80);
        tick();
        chk("t3_hold_addr2", {24'b0, mem_addr}, 8'h05);
        tick();
        chk("t3_new_req", {31'b0, mem_req}, 1);
        chk("t3_new_addr", {24'b0, mem_addr}, 8'h80);
        wait_valid("t3_wait", 40);
        chk("t3_instr_addr", {24'b0, instr_addr}, 8'h80);
        chk("t3_instr", {16'b0, instr}, 32'hDADB);

        // 4: pop 0x10, then relative branch by -2 lands back on 0x10
        lat = 0; instr_ready = 1'b0;
        apply_reset();
        branch_valid = 1'b1; branch_relative = 1'b0; branch_target = 8'h10;
        tick();
        branch_valid = 1'b0;
        chk("t4_abs_addr", {24'b0, mem_addr}, 8'h10);
        wait_valid("t4_wait", 20);
        chk("t4_first_addr", {24'b0, instr_addr}, 8'h10);
        chk("t4_first", {16'b0, instr}, 32'h4A4B);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch_valid = 1'b1; branch_relative = 1'b1; branch_offset = 8'hFE;
        tick();
        branch_valid = 1'b0; branch_relative = 1'b0;
        chk("t4_rel_addr", {24'b0, mem_addr}, 8'h10);
        chk("t4_rel_ip", {24'b0, ip}, 8'h10);
        chk("t4_rel_flush", {31'b0, instr_valid}, 0);
        wait_valid("t4_wait2", 20);
        chk("t4_refetch_addr", {24'b0, instr_addr}, 8'h10);

        // 5: instruction straddling the address wrap
        mem[0] = 8'hCD;
        apply_reset();
        branch_valid = 1'b1; branch_relative = 1'b0; branch_target = 8'hFF;
        tick();
        branch_valid = 1'b0;
        wait_valid("t5_wait", 20);
        chk("t5_instr", {16'b0, instr}, 32'hABCD);
        chk("t5_instr_addr", {24'b0, instr_addr}, 8'hFF);
        chk("t5_ip", {24'b0, ip}, 8'h01);
        chk("t5_req_pending", {31'b0, mem_req}, 1);

        // 6: asynchronous reset mid-cycle with a request and one queued entry
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_req", {31'b0, mem_req}, 0);
        chk("t6_async_valid", {31'b0, instr_valid}, 0);
        chk("t6_async_busy", {31'b0, busy}, 0);
        chk("t6_async_ip", {24'b0, ip}, 0);
        tick();
        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk("t6_restart_req", {31'b0, mem_req}, 1);
        chk("t6_restart_addr", {24'b0, mem_addr}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Parametrised successor to the fixed two-stage FETCH_MSB_IR/FETCH_LSB_IR fetch sequence. Fetches instructions of INSTR_BYTES memory words, MSB first, over a req/ack memory port, and buffers complete instructions in a small queue. Delivers them to decode over a valid/ready handshake. Supports absolute and relative redirects, with flush and safe discard of in-flight reads.

Parameters:
MEMORY_ADDRESS_BITS, 8, byte-address width; all address arithmetic is modulo 2^MEMORY_ADDRESS_BITS.
MEMORY_DATA_BITS, 8, width of one memory word.
INSTR_BYTES, 2, memory words per instruction (>=1).
JUMP_OFFSET_BITS, 8, signed relative-branch offset width.
QUEUE_DEPTH, 2, complete instructions buffered (>=1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  permits new memory requests
mem_req  out  1  read request, held until acked
mem_addr  out  MEMORY_ADDRESS_BITS  read address, stable while mem_req=1
mem_ack  in  1  read complete; mem_rdata valid in the same cycle
mem_rdata  in  MEMORY_DATA_BITS  read data
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts the head
instr  out  INSTR_BYTES*MEMORY_DATA_BITS  head instruction; first-fetched word in MSBs
instr_addr  out  MEMORY_ADDRESS_BITS  address of the head's first word
branch_valid  in  1  redirect request, single-cycle
branch_relative  in  1  1 = relative, 0 = absolute
branch_target  in  MEMORY_ADDRESS_BITS  absolute target
branch_offset  in  JUMP_OFFSET_BITS  signed relative offset
ip  out  MEMORY_ADDRESS_BITS  address of the next word to request
busy  out  1  request outstanding or discard pending

Behaviour:
- Reset (async assert, sync release): mem_req=0, mem_addr=0, ip=0, queue empty, instr_valid=0, instr=0, instr_addr=0, busy=0, word counter=0, last_next=0, FSM=IDLE.
- FSM states: IDLE, REQ, DISCARD. All outputs are registered.
- IDLE -> REQ when enable=1 and the queue is not full, or will have free space this cycle due to a pop. On entry, drive mem_req=1 and mem_addr=ip.
- REQ, on mem_ack:
  - Capture mem_rdata into slot word_cnt of the assembly register and set ip=ip+1.
  - If word_cnt < INSTR_BYTES-1: increment word_cnt and issue the next request back-to-back in the next cycle, unless a branch arrives.
  - If word_cnt = INSTR_BYTES-1: push {assembly, start address} into the queue and reset word_cnt to 0. Continue fetching if enable=1 and space remains; otherwise go to IDLE with mem_req=0.
- Push and pop in the same cycle with the queue full is legal; the occupancy is unchanged.
- Latency: with zero-wait ack, one word per cycle. instr_valid rises the cycle after the final word's ack edge.
- enable=0 never retracts a pending request; the fetch completes the current word only, and no new request issues. The partial assembly is kept, and fetching resumes when enable returns to 1.
- Queue behaviour: instr_valid=1 whenever the queue is non-empty. A pop occurs when instr_valid and instr_ready are both 1.
- On each pop, last_next = popped instr_addr + INSTR_BYTES.
- Branch (branch_valid=1):
  - Target: absolute uses branch_target. Relative uses last_next + sign-extended branch_offset, where last_next includes any pop in the same cycle.
  - Flush: the queue and the partial assembly are flushed, the next cycle has instr_valid=0, ip=target, and word_cnt=0.
  - Pop precedence: a pop in the same cycle still completes (the consumer owns that instruction); the remaining entries are flushed.
  - If mem_req=1 and mem_ack=0: go to DISCARD and hold mem_req/mem_addr until ack. The acked data is dropped, and then the first request issues at the target.
  - If mem_ack=1 in the branch cycle: that data is dropped.
  - A branch arriving during DISCARD updates the target and stays in DISCARD.
- busy = (mem_req=1) or (state=DISCARD).
- Wrap: ip and mem_addr wrap from 2^MEMORY_ADDRESS_BITS-1 to 0, so an instruction may straddle the wrap.
- Reset mid-operation: outputs return to reset values immediately. A late mem_ack after reset is ignored because no request is pending.

Test Plan:
1. Memory[0]=0x12, [1]=0x34, zero-wait ack, enable=1, instr_ready=1 -> instr=0x1234, instr_addr=0x00, ip=0x02; instr_valid rises the cycle after the second ack.
2. instr_ready=0, QUEUE_DEPTH=2, zero-wait ack -> after 4 acks, mem_req stays 0, ip=0x04, instr_valid=1. Pop once -> a request issues at 0x04 and instr shows the second instruction.
3. 3-cycle ack latency; absolute branch to 0x80 asserted while a request at 0x05 is pending -> mem_req stays high at 0x05 until ack, the data is discarded, the next request is at 0x80, and no instruction from 0x04/0x05 appears.
4. Pop instr_addr=0x10, then a relative branch with offset 0xFE (-2) -> target 0x10; the next mem_addr is 0x10.
5. Absolute branch to 0xFF, memory[0xFF]=0xAB, [0x00]=0xCD -> instr=0xABCD, instr_addr=0xFF, ip=0x01.
6. Assert reset asynchronously mid-cycle while mem_req=1 and the queue holds 1 entry -> mem_req=0 and instr_valid=0 with no clock edge. After release with enable=1, fetching restarts at 0x00.
